// File: rtl/affine_io_sequencer.sv
// Switch/LED front end for the affine datapath: debounced handshake, operand capture, run control.
// Latency: press/release strobe 2+DEBOUNCE_CYCLES cycles after SW[8] moves; start 1 cycle after y release strobe.
// Backpressure: none; button strobes outside the waiting states (e.g. in RUN) are dropped, not queued.
module affine_io_sequencer #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int CNT_W           = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [9:0] SW,
  output logic [7:0] LED,
  output logic       start,
  output logic [7:0] x1,
  output logic [7:0] y1,
  input  logic       done,
  input  logic [7:0] x2,
  input  logic [7:0] y2,
  output logic       busy,
  output logic       err
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WX_P   = 3'd1,
    WX_R   = 3'd2,
    WY_P   = 3'd3,
    WY_R   = 3'd4,
    RUN    = 3'd5,
    SHOW_X = 3'd6,
    SHOW_Y = 3'd7
  } state_t;

  // synchroniser: bit 1 = enable (SW[9]), bit 0 = button (SW[8])
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic             db_q, db_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  state_t           state_q, state_d;
  logic [7:0]       x1_q, x1_d;
  logic [7:0]       y1_q, y1_d;
  logic [7:0]       rx2_q, rx2_d;
  logic [7:0]       ry2_q, ry2_d;
  logic [7:0]       led_q, led_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] tmo_inc;
  logic             en;

  assign en = sync2_q[1];

  // Synchronise SW[9:8] and debounce the button into one-cycle press/release strobes
  always_comb begin
    sync1_d   = SW[9:8];
    sync2_d   = sync1_q;
    db_d      = db_q;
    db_cnt_d  = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q[0] != db_q) begin
      // the level flips on the Nth consecutive disagreeing cycle; strobes fire on that same edge
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d      = ~db_q;
        press_d   = ~db_q;
        release_d = db_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Saturating timeout increment; only meaningful while in RUN
  always_comb begin
    tmo_inc = (tmo_q == {CNT_W{1'b1}}) ? tmo_q : tmo_q + CNT_W'(1);
  end

  // Sequencer next-state: enable drop beats everything, done beats timeout
  always_comb begin
    state_d = state_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    rx2_d   = rx2_q;
    ry2_d   = ry2_q;
    err_d   = err_q;
    start_d = 1'b0;
    tmo_d   = '0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   state_d = WX_P;
        WX_P:   if (press_q) begin
                  x1_d    = SW[7:0];
                  state_d = WX_R;
                end
        WX_R:   if (release_q) state_d = WY_P;
        WY_P:   if (press_q) begin
                  y1_d    = SW[7:0];
                  state_d = WY_R;
                end
        WY_R:   if (release_q) begin
                  start_d = 1'b1;
                  err_d   = 1'b0;
                  state_d = RUN;
                end
        RUN:    begin
                  if (done) begin
                    rx2_d   = x2;
                    ry2_d   = y2;
                    state_d = SHOW_X;
                  end else if (tmo_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    err_d   = 1'b1;
                    state_d = WX_P;
                  end else begin
                    tmo_d = tmo_inc;
                  end
                end
        SHOW_X: if (press_q) state_d = SHOW_Y;
        SHOW_Y: if (release_q) state_d = WX_P;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN);
    case (state_d)
      SHOW_X:  led_d = rx2_d;
      SHOW_Y:  led_d = ry2_d;
      default: led_d = 8'd0;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= 1'b0;
      db_cnt_q  <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      state_q   <= IDLE;
      x1_q      <= '0;
      y1_q      <= '0;
      rx2_q     <= '0;
      ry2_q     <= '0;
      led_q     <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_cnt_q  <= db_cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      state_q   <= state_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      rx2_q     <= rx2_d;
      ry2_q     <= ry2_d;
      led_q     <= led_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign LED   = led_q;
  assign start = start_q;
  assign x1    = x1_q;
  assign y1    = y1_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_affine_io_sequencer.sv
// Directed bench for affine_io_sequencer with a hand-driven datapath stand-in.
// Latency: checks sampled 1 time unit after each rising edge at hand-computed cycle offsets.
// Backpressure: none; the bench drives every input directly.
module tb_affine_io_sequencer;

  localparam int DB  = 2;
  localparam int TMO = 255;
  localparam int HOLD = 2 * (2 + DB);

  localparam logic [31:0] S_IDLE   = 32'd0;
  localparam logic [31:0] S_WX_P   = 32'd1;
  localparam logic [31:0] S_SHOW_X = 32'd6;

  logic       Clock;
  logic       Reset;
  logic [9:0] SW;
  logic [7:0] LED;
  logic       start;
  logic [7:0] x1;
  logic [7:0] y1;
  logic       done;
  logic [7:0] x2;
  logic [7:0] y2;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;
  int start_base;

  affine_io_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (8)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .SW   (SW),
    .LED  (LED),
    .start(start),
    .x1   (x1),
    .y1   (y1),
    .done (done),
    .x2   (x2),
    .y2   (y2),
    .busy (busy),
    .err  (err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(negedge Clock) if (start === 1'b1) start_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st();
    return 32'(dut.state_q);
  endfunction

  // full press/release of SW[8] while in WX_P, capturing x
  task automatic capture_x(input logic [7:0] v);
    SW[7:0] = v;
    SW[8] = 1'b1;
    tick(HOLD);
    chk("x1_capture", 32'(x1), 32'(v));
    SW[8] = 1'b0;
    tick(HOLD);
  endtask

  // press/release capturing y; checks start timing; returns one cycle after start
  task automatic capture_y_start(input logic [7:0] v);
    SW[7:0] = v;
    SW[8] = 1'b1;
    tick(HOLD);
    chk("y1_capture", 32'(y1), 32'(v));
    SW[8] = 1'b0;
    tick(2 + DB);
    chk("start_before", 32'(start), 32'd0);
    tick(1);
    chk("start_pulse", 32'(start), 32'd1);
    chk("busy_run", 32'(busy), 32'd1);
    chk("err_cleared", 32'(err), 32'd0);
    tick(1);
    chk("start_single", 32'(start), 32'd0);
  endtask

  // datapath answers 10 cycles after start; bench is 1 cycle past start on entry
  task automatic finish_run(input logic [7:0] rx, input logic [7:0] ry);
    tick(8);
    done = 1'b1; x2 = rx; y2 = ry;
    tick(1);
    done = 1'b0; x2 = 8'h00; y2 = 8'h00;
    chk("led_x2", 32'(LED), 32'(rx));
    chk("busy_show", 32'(busy), 32'd0);
  endtask

  // press/release while showing results, ending back in WX_P
  task automatic show_cycle(input logic [7:0] rx, input logic [7:0] ry);
    SW[8] = 1'b1;
    tick(2 + DB);
    chk("led_x2_hold", 32'(LED), 32'(rx));
    tick(1);
    chk("led_y2", 32'(LED), 32'(ry));
    tick(HOLD - 3 - DB);
    SW[8] = 1'b0;
    tick(3 + DB);
    chk("led_zero_after", 32'(LED), 32'd0);
    chk("state_wx_p", st(), S_WX_P);
    tick(3);
  endtask

  initial begin
    Reset = 1'b1; SW = 10'd0; done = 1'b0; x2 = 8'd0; y2 = 8'd0;
    tick(3);
    chk("rst_led", 32'(LED), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_x1", 32'(x1), 32'd0);
    chk("rst_state", st(), S_IDLE);
    Reset = 1'b0;
    tick(2);

    // enable: 2 sync cycles then WX_P
    SW[9] = 1'b1;
    tick(3);
    chk("enter_wx_p", st(), S_WX_P);

    // done outside RUN is ignored
    done = 1'b1; x2 = 8'h55; y2 = 8'h66;
    tick(1);
    done = 1'b0;
    tick(1);
    chk("done_ignored_state", st(), S_WX_P);
    chk("done_ignored_led", 32'(LED), 32'd0);

    // main run: (4,6) -> (26,-18)
    start_base = start_cnt;
    capture_x(8'd4);
    capture_y_start(8'd6);
    finish_run(8'd26, 8'hEE);
    show_cycle(8'd26, 8'hEE);
    chk("main_start_count", 32'(start_cnt - start_base), 32'd1);

    // back-to-back runs
    start_base = start_cnt;
    capture_x(8'd40);
    capture_y_start(8'd21);
    finish_run(8'd50, 8'hF6);
    show_cycle(8'd50, 8'hF6);
    capture_x(8'd20);
    capture_y_start(8'd55);
    finish_run(8'd56, 8'd11);
    show_cycle(8'd56, 8'd11);
    chk("b2b_start_count", 32'(start_cnt - start_base), 32'd2);

    // one-cycle glitch on SW[8] must not capture
    SW[7:0] = 8'h7F;
    SW[8] = 1'b1;
    tick(1);
    SW[8] = 1'b0;
    tick(HOLD);
    chk("glitch_x1", 32'(x1), 32'd20);
    chk("glitch_state", st(), S_WX_P);

    // timeout: no done for TMO cycles
    capture_x(8'd3);
    capture_y_start(8'd9);
    tick(TMO - 2);
    chk("tmo_err_before", 32'(err), 32'd0);
    chk("tmo_busy_before", 32'(busy), 32'd1);
    tick(1);
    chk("tmo_err_set", 32'(err), 32'd1);
    chk("tmo_busy_clear", 32'(busy), 32'd0);
    chk("tmo_state", st(), S_WX_P);
    capture_x(8'd5);
    chk("err_sticky", 32'(err), 32'd1);
    capture_y_start(8'd7);
    finish_run(8'd1, 8'd2);
    show_cycle(8'd1, 8'd2);

    // reset mid-RUN
    capture_x(8'd11);
    capture_y_start(8'd12);
    tick(2);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    chk("rr_led", 32'(LED), 32'd0);
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_state", st(), S_IDLE);
    chk("rr_x1", 32'(x1), 32'd0);
    chk("rr_y1", 32'(y1), 32'd0);
    tick(3);
    chk("rr_reenter", st(), S_WX_P);

    // drop enable during SHOW_X
    capture_x(8'd33);
    capture_y_start(8'd44);
    finish_run(8'd77, 8'd88);
    chk("drop_in_show", st(), S_SHOW_X);
    SW[9] = 1'b0;
    tick(3);
    chk("drop_led", 32'(LED), 32'd0);
    chk("drop_state", st(), S_IDLE);
    SW[9] = 1'b1;
    tick(3);
    chk("drop_reenter", st(), S_WX_P);
    chk("drop_x1_kept", 32'(x1), 32'd33);
    chk("drop_y1_kept", 32'(y1), 32'd44);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
